// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
//   Round-robin arbiter plus write sequencer for one shared WIDTH-bit
//   level-sensitive latch bank. The winner's data is captured once on the
//   grant edge. latch_en is then driven through setup / open / hold phases,
//   so latch_d never moves while the latch is transparent.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-requester write request (level, held until ack)
//   wdata       requester i data in bits [i*WIDTH +: WIDTH]
//   gnt         one-hot grant, high for the whole transaction
//   ack         one-cycle completion pulse to the granted requester
//   latch_d     registered data to the latch bank
//   latch_en    registered enable to the latch bank
//   busy        high whenever the sequencer is not idle
module latch_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      latch_d,
  output logic                  latch_en,
  output logic                  busy
);

  localparam int MAXC = (SETUP_CYC > OPEN_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(NREQ);

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] O_LAST = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [WIDTH-1:0] win_data;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  // A requester whose ack is on the wire this cycle has not yet dropped req.
  // Masking it keeps it from being granted a second, unintended write.
  assign elig = req & ~ack;

  // Cyclic search from ptr. The loop runs backwards so the closest index
  // to ptr is assigned last and wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        win   = wrap(int'(ptr) + k);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (win == PW'(k)) win_data = wdata[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gnt      <= '0;
      ack      <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (found) begin
          gnt     <= NREQ'(1) << win;
          latch_d <= win_data;
          busy    <= 1'b1;
          ptr     <= wrap(int'(win) + 1);
          cnt     <= '0;
          state   <= SETUP;
        end
        SETUP: if (cnt == S_LAST) begin
          cnt      <= '0;
          latch_en <= 1'b1;
          state    <= OPEN;
        end else cnt <= cnt + CW'(1);
        OPEN: if (cnt == O_LAST) begin
          cnt      <= '0;
          latch_en <= 1'b0;
          state    <= HOLD;
        end else cnt <= cnt + CW'(1);
        HOLD: if (cnt == H_LAST) begin
          cnt   <= '0;
          ack   <= gnt;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
module tb_latch_write_arbiter;
  localparam int N = 4, W = 8, S = 1, O = 2, H = 1;
  localparam int T = S + O + H;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   latch_d;
  logic           latch_en, busy;

  int vectors = 0, miscompares = 0;

  latch_write_arbiter #(.NREQ(N), .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
    .latch_d(latch_d), .latch_en(latch_en), .busy(busy));

  always #5 clk = ~clk;

  // Transaction-timeline model: a write is described only by its owner and
  // the number of edges since its grant edge.
  bit         m_act;
  int         m_t, m_own, m_ptr;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_d;

  task automatic model_reset();
    m_act = 0; m_t = 0; m_own = 0; m_ptr = 0; m_ack = '0; m_d = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] el;
    bit f;
    int w;
    if (!rst_n) begin model_reset(); return; end
    if (m_act) begin
      m_t++;
      m_ack = '0;
      if (m_t == T) begin m_act = 0; m_ack = '0; m_ack[m_own] = 1'b1; end
    end else begin
      el = req & ~m_ack;
      m_ack = '0;
      f = 0; w = 0;
      for (int k = 0; k < N; k++)
        if (!f && el[(m_ptr + k) % N]) begin f = 1; w = (m_ptr + k) % N; end
      if (f) begin
        m_act = 1; m_t = 0; m_own = w;
        m_d = wdata[w*W +: W];
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  function automatic logic [2*N+W+1:0] expv();
    logic [N-1:0] g;
    logic e;
    g = '0;
    if (m_act) g[m_own] = 1'b1;
    e = m_act && (m_t >= S) && (m_t < S + O);
    return {g, m_ack, m_act, e, m_d};
  endfunction

  function automatic logic [2*N+W+1:0] obsv();
    return {gnt, ack, busy, latch_en, latch_d};
  endfunction

  // Advance one clock, update the model at the edge, return just after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2*N+W+1:0] o;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      o = obsv(); vectors++;
      if (o !== '0) begin miscompares++; $display("FAIL reset_idle c=%0d got=%h exp=0", c, o); end
    end
    #2 rst_n = 1'b0; #1;
    o = obsv(); vectors++;
    if (o !== '0) begin miscompares++; $display("FAIL reset_async got=%h exp=0", o); end
    model_reset();
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [2*N+W+1:0] e;
    wdata[2*W +: W] = 8'hA5; req = 4'b0100;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (ack[2]) req[2] = 1'b0;
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL single_model k=%0d got=%h exp=%h", k, obsv(), e); end
      vectors++;
      if (latch_en !== (k >= 1 && k <= 2)) begin miscompares++; $display("FAIL single_en k=%0d got=%b", k, latch_en); end
      vectors++;
      if (ack !== ((k == 4) ? 4'b0100 : 4'b0000)) begin miscompares++; $display("FAIL single_ack k=%0d got=%b", k, ack); end
      if (k == 0) begin
        vectors++;
        if (gnt !== 4'b0100 || latch_d !== 8'hA5 || busy !== 1'b1) begin
          miscompares++; $display("FAIL single_grant got gnt=%b d=%h busy=%b exp 0100/a5/1", gnt, latch_d, busy);
        end
      end
      if (k == 4) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int edges[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev_g, dropped;
    logic [2*N+W+1:0] e;
    apply_reset();
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(8'h10 * (i + 1) + i);
    req = 4'b1111; prev_g = '0; dropped = '0;
    for (int c = 0; c < 26; c++) begin
      tick();
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, obsv(), e); end
      for (int i = 0; i < N; i++) if (gnt[i] && !prev_g[i]) begin
        order.push_back(i); edges.push_back(c);
        vectors++;
        if (latch_d !== wdata[i*W +: W]) begin miscompares++; $display("FAIL rr_data req=%0d got=%h exp=%h", i, latch_d, wdata[i*W +: W]); end
      end
      prev_g = gnt;
      req = req | dropped; dropped = '0;
      for (int i = 0; i < N; i++) if (ack[i]) begin req[i] = 1'b0; dropped[i] = 1'b1; end
    end
    req = '0;
    vectors++;
    if (order.size() < 5) begin miscompares++; $display("FAIL rr_count got=%0d exp>=5", order.size()); end
    else for (int k = 0; k < 5; k++) begin
      vectors++;
      if (order[k] !== exp_order[k]) begin miscompares++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, order[k], exp_order[k]); end
      if (k > 0) begin
        vectors++;
        if (edges[k] - edges[k-1] !== 5) begin miscompares++; $display("FAIL rr_spacing k=%0d got=%0d exp=5", k, edges[k] - edges[k-1]); end
      end
    end
    tick(); tick();
  endtask

  task automatic test_no_regrant();
    int second;
    bit seen0;
    logic hold0;
    logic [2*N+W+1:0] e;
    apply_reset();
    wdata[0 +: W] = 8'h11; wdata[W +: W] = 8'h22;
    req = 4'b0011; second = -1; seen0 = 0; hold0 = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL noregrant_model c=%0d got=%h exp=%h", c, obsv(), e); end
      if (seen0 && second < 0 && gnt != 0) second = $clog2(gnt);
      if (hold0) begin req[0] = 1'b0; hold0 = 0; end
      if (ack[0]) begin seen0 = 1; hold0 = 1; end
      if (ack[1]) req[1] = 1'b0;
    end
    vectors++;
    if (second !== 1) begin miscompares++; $display("FAIL noregrant_second got=%0d exp=1", second); end
    req = '0; tick();
  endtask

  task automatic test_drop_mid();
    logic [2*N+W+1:0] e;
    apply_reset();
    wdata[W +: W] = 8'h3C; req = 4'b0010;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 1) begin req[1] = 1'b0; wdata[W +: W] = 8'hFF; end
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL drop_model k=%0d got=%h exp=%h", k, obsv(), e); end
      vectors++;
      if (latch_d !== 8'h3C) begin miscompares++; $display("FAIL drop_data k=%0d got=%h exp=3c", k, latch_d); end
      if (k == 4) begin
        vectors++;
        if (ack !== 4'b0010) begin miscompares++; $display("FAIL drop_ack got=%b exp=0010", ack); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2*N+W+1:0] e;
    apply_reset();
    wdata[0 +: W] = 8'h5A; req = 4'b0001;
    tick(); req = '0; tick(); tick();
    #2 rst_n = 1'b0; #1;
    vectors++;
    if (latch_en !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL resetmid_async got en=%b gnt=%b busy=%b exp 0/0/0", latch_en, gnt, busy);
    end
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (ack !== '0) begin miscompares++; $display("FAIL resetmid_ack c=%0d got=%b exp=0", c, ack); end
    end
    rst_n = 1'b1;
    wdata[3*W +: W] = 8'hC3; req = 4'b1000;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (ack[3]) req[3] = 1'b0;
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL resetmid_model k=%0d got=%h exp=%h", k, obsv(), e); end
      if (k == 0) begin
        vectors++;
        if (gnt !== 4'b1000 || latch_d !== 8'hC3) begin miscompares++; $display("FAIL resetmid_grant got gnt=%b d=%h exp 1000/c3", gnt, latch_d); end
      end
    end
    // Pointer is now 0 again: requesters 0 and 2 together must grant 0.
    req = 4'b0101; tick();
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL resetmid_ptr got=%b exp=0001", gnt); end
    req = '0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_random();
    logic [2*N+W+1:0] e;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      e = expv(); vectors++;
      if (obsv() !== e) begin miscompares++; $display("FAIL random_model c=%0d got=%h exp=%h", c, obsv(), e); end
      for (int i = 0; i < N; i++) begin
        if (ack[i] && $urandom_range(3) != 0) req[i] = 1'b0;
        else if (!ack[i] && !gnt[i] && $urandom_range(3) == 0) begin
          if (!req[i]) wdata[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end
        if (gnt[i] && $urandom_range(2) == 0) wdata[i*W +: W] = W'($urandom);
        if (gnt[i] && $urandom_range(4) == 0) req[i] = 1'b0;
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_no_regrant();
    test_drop_mid();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
